// File: rtl/stream_fifo.sv
// stream_fifo: first-word-fall-through FIFO with valid/ready on both sides.
// Entry registers are loaded through a one-hot decode of the write pointer.
module stream_fifo #(
   parameter int WIDTH       = 16,
   parameter int DEPTH       = 8,
   parameter int AFULL_LEVEL = 6
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   flush,
   input  logic [WIDTH-1:0]       in_data,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [WIDTH-1:0]       out_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [$clog2(DEPTH):0] count,
   output logic                   afull
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [WIDTH-1:0] entry [DEPTH];
   logic [DEPTH-1:0] load;
   logic             push;
   logic             pop;

   assign in_ready  = (count != CW'(DEPTH));
   assign out_valid = (count != '0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;
   assign out_data  = entry[rd_ptr];
   assign afull     = (count >= CW'(AFULL_LEVEL));

   // One-hot entry load enable; a flush drops the offered word.
   always_comb begin
      load = '0;
      if (push && !flush) begin
         load[wr_ptr] = 1'b1;
      end
   end

   // Entry storage; contents need no reset since count gates visibility.
   always_ff @(posedge clock) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (load[i]) begin
            entry[i] <= in_data;
         end
      end
   end

   // Wrapping pointers and occupancy; flush beats push and pop.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         unique case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_stream_fifo.sv
// tb_stream_fifo: directed test-plan sequences plus random traffic,
// scored against a queue model by a negedge monitor.
module tb_stream_fifo;

   localparam int WIDTH = 16;
   localparam int DEPTH = 8;
   localparam int AFULL = 6;

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic             flush = 1'b0;
   logic [WIDTH-1:0] in_data = '0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [3:0]       count;
   logic             afull;

   int checks = 0;
   int errors = 0;
   logic saw_beef = 1'b0;

   logic [WIDTH-1:0] model [$];

   stream_fifo #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH),
      .AFULL_LEVEL(AFULL)
   ) dut (
      .clock(clock),
      .reset(reset),
      .flush(flush),
      .in_data(in_data),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .out_data(out_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .count(count),
      .afull(afull)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                  name, act, exp, $time);
      end
   endtask

   // Monitor: compare against the queue model, then advance the model
   // at the following rising edge using the sampled handshakes.
   initial begin
      logic m_push, m_pop, m_flush;
      logic [WIDTH-1:0] m_data;
      forever begin
         @(negedge clock);
         m_push = 1'b0;
         m_pop  = 1'b0;
         m_flush = 1'b0;
         m_data = '0;
         if (reset) begin
            model.delete();
         end else begin
            chk("count", 32'(count), 32'(model.size()));
            chk("out_valid", 32'(out_valid), 32'(model.size() != 0));
            chk("in_ready", 32'(in_ready), 32'(model.size() != DEPTH));
            chk("afull", 32'(afull), 32'(model.size() >= AFULL));
            if (model.size() != 0) begin
               chk("out_data", 32'(out_data), 32'(model[0]));
            end
            m_flush = flush;
            m_push  = in_valid && (model.size() != DEPTH);
            m_pop   = out_ready && (model.size() != 0);
            m_data  = in_data;
            if (m_pop && !m_flush && out_data == 16'hBEEF) begin
               saw_beef = 1'b1;
            end
         end
         @(posedge clock);
         if (!reset) begin
            if (m_flush) begin
               model.delete();
            end else begin
               if (m_pop) void'(model.pop_front());
               if (m_push) model.push_back(m_data);
            end
         end
      end
   end

   task automatic step(input logic v, input logic [WIDTH-1:0] d,
                       input logic r, input logic f);
      in_valid  = v;
      in_data   = d;
      out_ready = r;
      flush     = f;
      @(posedge clock);
      #1;
   endtask

   task automatic drain();
      for (int i = 0; i < 2 * DEPTH; i++) begin
         step(1'b0, '0, 1'b1, 1'b0);
      end
      step(1'b0, '0, 1'b0, 1'b0);
   endtask

   initial begin
      #12;
      chk("rst_count", 32'(count), 0);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_in_ready", 32'(in_ready), 1);
      chk("rst_afull", 32'(afull), 0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      step(1'b0, '0, 1'b0, 1'b0);

      // ordering and latency
      step(1'b1, 16'h0001, 1'b0, 1'b0);
      chk("lat_valid", 32'(out_valid), 1);
      chk("lat_data", 32'(out_data), 32'h0001);
      step(1'b1, 16'h0002, 1'b0, 1'b0);
      step(1'b1, 16'h0003, 1'b0, 1'b0);
      chk("ord_count", 32'(count), 3);
      for (int i = 1; i <= 3; i++) begin
         chk("ord_data", 32'(out_data), 32'(i));
         step(1'b0, '0, 1'b1, 1'b0);
      end
      chk("ord_empty", 32'(out_valid), 0);

      // fill to full
      for (int i = 0; i < DEPTH; i++) begin
         step(1'b1, 16'(16'h00A0 + i), 1'b0, 1'b0);
         chk("fill_afull", 32'(afull), 32'(i + 1 >= AFULL));
      end
      chk("full_in_ready", 32'(in_ready), 0);
      step(1'b1, 16'h00FF, 1'b0, 1'b0);
      chk("full_count", 32'(count), DEPTH);
      chk("full_head", 32'(out_data), 32'h00A0);
      step(1'b0, '0, 1'b1, 1'b0);
      chk("full_in_ready_back", 32'(in_ready), 1);
      chk("full_count_pop", 32'(count), DEPTH - 1);
      drain();

      // steady state at count 4, pointers wrap
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 16'(16'h0100 + i), 1'b0, 1'b0);
      end
      for (int i = 4; i < 24; i++) begin
         chk("ss_head", 32'(out_data), 32'(16'h0100 + i - 4));
         step(1'b1, 16'(16'h0100 + i), 1'b1, 1'b0);
         chk("ss_count", 32'(count), 4);
      end
      drain();

      // empty boundary
      chk("empty_valid", 32'(out_valid), 0);
      step(1'b1, 16'h5555, 1'b1, 1'b0);
      chk("empty_next_valid", 32'(out_valid), 1);
      chk("empty_next_data", 32'(out_data), 32'h5555);
      chk("empty_next_count", 32'(count), 1);
      drain();

      // flush with concurrent push and pop
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 16'(16'h0200 + i), 1'b0, 1'b0);
      end
      step(1'b1, 16'hBEEF, 1'b1, 1'b1);
      chk("flush_count", 32'(count), 0);
      chk("flush_valid", 32'(out_valid), 0);
      chk("flush_ready", 32'(in_ready), 1);
      chk("flush_afull", 32'(afull), 0);
      drain();

      // asynchronous reset mid-stream
      for (int i = 0; i < 7; i++) begin
         step(1'b1, 16'(16'h0300 + i), 1'b0, 1'b0);
      end
      in_valid = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      chk("arst_count", 32'(count), 0);
      chk("arst_valid", 32'(out_valid), 0);
      chk("arst_ready", 32'(in_ready), 1);
      chk("arst_afull", 32'(afull), 0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      step(1'b1, 16'h1234, 1'b0, 1'b0);
      chk("arst_first", 32'(out_data), 32'h1234);
      drain();

      // random traffic
      for (int i = 0; i < 2000; i++) begin
         step(1'($urandom_range(0, 3) != 0), 16'($urandom),
              1'($urandom_range(0, 2) != 0),
              1'($urandom_range(0, 63) == 0));
      end
      drain();

      chk("beef_never_out", 32'(saw_beef), 0);
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
